div_sequencer: RTL and testbench

// Upstream control stage for the unsigned shift-subtract Divider core. It accepts signed or

---
 rtl/div_sequencer.sv | 168 ++++++++++++++++
 tb/tb_div_sequencer.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/div_sequencer.sv
// Signed/unsigned front end for a shift-subtract divider: takes operands over valid/ready,
// runs the internal core on magnitudes, sign-corrects the result and holds it until taken.
module div_core #(
  parameter int N = 8
) (
  input  logic         i_clock,
  input  logic         i_reset,
  input  logic         i_start,
  input  logic [N-1:0] i_dividend,
  input  logic [N-1:0] i_divisor,
  output logic [N-1:0] o_quotient,
  output logic [N-1:0] o_remainder,
  output logic         o_finished
);
  localparam int CW = $clog2(N);

  logic [N-1:0]  rem_q, quo_q, dvs_q, rem_n, quo_n;
  logic [N:0]    trial, diff;
  logic [CW-1:0] cnt_q;
  logic          busy_q, ge;

  // The last of the N restoring steps is combinational, so results are valid only
  // while o_finished is high.
  assign trial       = {rem_q, quo_q[N-1]};
  assign diff        = trial - {1'b0, dvs_q};
  assign ge          = trial >= {1'b0, dvs_q};
  assign rem_n       = ge ? diff[N-1:0] : trial[N-1:0];
  assign quo_n       = {quo_q[N-2:0], ge};
  assign o_quotient  = quo_n;
  assign o_remainder = rem_n;
  assign o_finished  = busy_q && (cnt_q == CW'(N-1));

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      rem_q  <= '0;
      quo_q  <= '0;
      dvs_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      dvs_q <= i_divisor;
      if (i_start) begin
        rem_q  <= '0;
        quo_q  <= i_dividend;
        cnt_q  <= '0;
        busy_q <= 1'b1;
      end else if (busy_q) begin
        rem_q <= rem_n;
        quo_q <= quo_n;
        if (o_finished) busy_q <= 1'b0;
        else            cnt_q  <= cnt_q + 1'b1;
      end
    end
  end
endmodule

module div_sequencer #(
  parameter int N      = 8,
  parameter int SIGNED = 1
) (
  input  logic         i_clock,
  input  logic         i_reset_n,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic [N-1:0] i_dividend,
  input  logic [N-1:0] i_divisor,
  output logic         o_valid,
  input  logic         i_ready,
  output logic [N-1:0] o_quotient,
  output logic [N-1:0] o_remainder,
  output logic         o_div_zero,
  output logic         o_overflow
);
  typedef enum logic [1:0] {IDLE, SETUP, RUN, DONE} state_t;

  localparam logic         SGN     = (SIGNED != 0);
  localparam logic [N-1:0] MIN_VAL = {1'b1, {(N-1){1'b0}}};

  state_t       state, state_nxt;
  logic         sign_q, sign_r, zero_q, ovf_q;
  logic [N-1:0] mag_dvd, mag_dvs, raw_dvd, core_q, core_r;
  logic         core_start, core_fin, dvd_neg, dvs_neg, accept;

  assign dvd_neg = SGN & i_dividend[N-1];
  assign dvs_neg = SGN & i_divisor[N-1];
  assign accept  = i_valid & o_ready;

  div_core #(.N(N)) u_core (
    .i_clock    (i_clock),
    .i_reset    (~i_reset_n),
    .i_start    (core_start),
    .i_dividend (mag_dvd),
    .i_divisor  (mag_dvs),
    .o_quotient (core_q),
    .o_remainder(core_r),
    .o_finished (core_fin)
  );

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) state <= IDLE;
    else            state <= state_nxt;
  end

  // SETUP gives the core one clock to register the divisor before it starts.
  always_comb begin
    state_nxt  = state;
    o_ready    = 1'b0;
    o_valid    = 1'b0;
    core_start = 1'b0;
    case (state)
      IDLE: begin
        o_ready = 1'b1;
        if (i_valid) state_nxt = SETUP;
      end
      SETUP: begin
        if (zero_q) state_nxt = DONE;
        else begin
          core_start = 1'b1;
          state_nxt  = RUN;
        end
      end
      RUN:  if (core_fin) state_nxt = DONE;
      DONE: begin
        o_valid = 1'b1;
        if (i_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      sign_q      <= 1'b0;
      sign_r      <= 1'b0;
      zero_q      <= 1'b0;
      ovf_q       <= 1'b0;
      mag_dvd     <= '0;
      mag_dvs     <= '0;
      raw_dvd     <= '0;
      o_quotient  <= '0;
      o_remainder <= '0;
      o_div_zero  <= 1'b0;
      o_overflow  <= 1'b0;
    end else begin
      if (accept) begin
        sign_q  <= dvd_neg ^ dvs_neg;
        sign_r  <= dvd_neg;
        mag_dvd <= dvd_neg ? -i_dividend : i_dividend;
        mag_dvs <= dvs_neg ? -i_divisor : i_divisor;
        raw_dvd <= i_dividend;
        zero_q  <= (i_divisor == '0);
        ovf_q   <= SGN && (i_dividend == MIN_VAL) && (i_divisor == '1);
      end
      if (state == SETUP && zero_q) begin
        o_quotient  <= '1;
        o_remainder <= raw_dvd;
        o_div_zero  <= 1'b1;
        o_overflow  <= 1'b0;
      end else if (state == RUN && core_fin) begin
        // MIN / -1 needs no special case: |MIN| wraps back to MIN in N bits.
        o_quotient  <= sign_q ? -core_q : core_q;
        o_remainder <= sign_r ? -core_r : core_r;
        o_div_zero  <= 1'b0;
        o_overflow  <= ovf_q;
      end
    end
  end
endmodule

// File: tb/tb_div_sequencer.sv
// Bench for div_sequencer: an unsigned and a signed instance checked every cycle against
// an arithmetic model, plus directed operations with hand-computed results.
module tb_div_sequencer;
  localparam int N = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       vin[2], rin[2];
  logic [7:0] a_in[2], b_in[2];
  logic       ordy[2], ovld[2], odz[2], oov[2];
  logic [7:0] oq[2], orr[2];

  int checks = 0, failures = 0, cyc = 0, starts = 0;
  bit         busy[2];
  int         exp_edge[2];
  logic [7:0] eq[2], er[2];
  logic       edz[2], eov[2];

  always #5 clk = ~clk;

  div_sequencer #(.N(N), .SIGNED(0)) u_uns (
    .i_clock(clk), .i_reset_n(rst_n), .i_valid(vin[0]), .o_ready(ordy[0]),
    .i_dividend(a_in[0]), .i_divisor(b_in[0]), .o_valid(ovld[0]), .i_ready(rin[0]),
    .o_quotient(oq[0]), .o_remainder(orr[0]), .o_div_zero(odz[0]), .o_overflow(oov[0]));

  div_sequencer #(.N(N), .SIGNED(1)) u_sgn (
    .i_clock(clk), .i_reset_n(rst_n), .i_valid(vin[1]), .o_ready(ordy[1]),
    .i_dividend(a_in[1]), .i_divisor(b_in[1]), .o_valid(ovld[1]), .i_ready(rin[1]),
    .o_quotient(oq[1]), .o_remainder(orr[1]), .o_div_zero(odz[1]), .o_overflow(oov[1]));

  task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s dut%0d actual=%0h required=%0h", nm, d, act, req);
    end
  endtask

  function automatic void model(input bit sgn, input logic [7:0] a, input logic [7:0] b,
                                output logic [7:0] q, output logic [7:0] r,
                                output logic dz, output logic ov);
    int x, y;
    x  = sgn ? int'($signed(a)) : int'(a);
    y  = sgn ? int'($signed(b)) : int'(b);
    dz = 1'b0;
    ov = 1'b0;
    if (y == 0) begin
      q = 8'hFF; r = a; dz = 1'b1;
    end else if (sgn && x == -128 && y == -1) begin
      q = 8'h80; r = 8'h00; ov = 1'b1;
    end else begin
      q = 8'(x / y); r = 8'(x % y);
    end
  endfunction

  // Model: one op in flight per instance; result due N+1 edges after accept (1 on zero).
  always @(posedge clk) begin
    logic [7:0] mq, mr;
    logic       mdz, mov;
    cyc <= cyc + 1;
    for (int d = 0; d < 2; d++) begin
      if (!rst_n) busy[d] <= 1'b0;
      else if (busy[d]) begin
        if (cyc >= exp_edge[d] && rin[d]) busy[d] <= 1'b0;
      end else if (vin[d]) begin
        model(d == 1, a_in[d], b_in[d], mq, mr, mdz, mov);
        busy[d]     <= 1'b1;
        eq[d]       <= mq;
        er[d]       <= mr;
        edz[d]      <= mdz;
        eov[d]      <= mov;
        exp_edge[d] <= cyc + 1 + ((b_in[d] == 8'h00) ? 1 : N + 1);
      end
    end
  end

  always @(negedge clk) begin
    logic ev;
    for (int d = 0; d < 2; d++) begin
      if (!rst_n) begin
        chk("rst_valid", d, ovld[d], 0);
        chk("rst_quot", d, oq[d], 0);
        chk("rst_rem", d, orr[d], 0);
        chk("rst_flags", d, {odz[d], oov[d]}, 0);
      end else begin
        ev = busy[d] && (cyc >= exp_edge[d]);
        chk("m_valid", d, ovld[d], ev);
        chk("m_ready", d, ordy[d], !busy[d]);
        if (ev) begin
          chk("m_quot", d, oq[d], eq[d]);
          chk("m_rem", d, orr[d], er[d]);
          chk("m_divzero", d, odz[d], edz[d]);
          chk("m_overflow", d, oov[d], eov[d]);
        end
      end
    end
  end

  always @(negedge clk) if (u_sgn.core_start === 1'b1) starts++;

  task automatic run_op(input int d, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] xq, input logic [7:0] xr, input logic xdz,
                        input logic xov, input int xlat, input int stall);
    int t;
    @(negedge clk);
    rin[d] = 1'b0; vin[d] = 1'b1; a_in[d] = a; b_in[d] = b;
    t = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (i == 1) begin
        vin[d] = 1'b0; a_in[d] = 8'h5A; b_in[d] = 8'h03;
      end
      if (ovld[d]) begin t = i; break; end
    end
    chk("latency", d, t - 1, xlat);
    chk("d_quot", d, oq[d], xq);
    chk("d_rem", d, orr[d], xr);
    chk("d_divzero", d, odz[d], xdz);
    chk("d_overflow", d, oov[d], xov);
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      chk("stall_valid", d, ovld[d], 1);
      chk("stall_quot", d, oq[d], xq);
      chk("stall_rem", d, orr[d], xr);
      chk("stall_ready", d, ordy[d], 0);
    end
    rin[d] = 1'b1;
    @(negedge clk);
    chk("release_valid", d, ovld[d], 0);
    chk("release_ready", d, ordy[d], 1);
    rin[d] = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int s0, idx, nres;
    bit pend;
    logic [7:0] res[4];
    logic [7:0] ba[4], bb[4], bq[4];
    ba = '{8'd50, 8'hCE, 8'd9, 8'd127};
    bb = '{8'd5, 8'd5, 8'd0, 8'h80};
    bq = '{8'h0A, 8'hF6, 8'hFF, 8'h00};
    for (int d = 0; d < 2; d++) begin
      vin[d] = 1'b0; rin[d] = 1'b0; a_in[d] = 8'h00; b_in[d] = 8'h00;
    end
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", 0, ordy[0], 1);
    chk("ready_after_reset", 1, ordy[1], 1);

    run_op(0, 8'd200, 8'd7, 8'd28, 8'd4, 1'b0, 1'b0, 9, 0);
    s0 = starts;
    run_op(1, 8'hF9, 8'h02, 8'hFD, 8'hFF, 1'b0, 1'b0, 9, 0);
    chk("one_start", 1, starts - s0, 1);
    run_op(1, 8'h07, 8'hFE, 8'hFD, 8'h01, 1'b0, 1'b0, 9, 0);
    s0 = starts;
    run_op(1, 8'd55, 8'h00, 8'hFF, 8'd55, 1'b1, 1'b0, 1, 0);
    chk("zero_no_start", 1, starts - s0, 0);

    // Back-to-back with i_valid held high and the consumer always ready.
    @(negedge clk);
    rin[1] = 1'b1; vin[1] = 1'b1; a_in[1] = ba[0]; b_in[1] = bb[0];
    idx = 0; nres = 0; pend = ordy[1];
    for (int i = 0; i < 300 && nres < 4; i++) begin
      @(negedge clk);
      if (ovld[1]) begin res[nres] = oq[1]; nres++; end
      if (pend) begin
        idx++; pend = 1'b0;
        if (idx < 4) begin a_in[1] = ba[idx]; b_in[1] = bb[idx]; end
        else vin[1] = 1'b0;
      end
      if (vin[1] && ordy[1]) pend = 1'b1;
    end
    chk("b2b_count", 1, nres, 4);
    for (int k = 0; k < 4; k++) chk("b2b_quot", 1, res[k], bq[k]);

    run_op(1, 8'h80, 8'hFF, 8'h80, 8'h00, 1'b0, 1'b1, 9, 20);

    // Abort in the fourth RUN cycle.
    @(negedge clk);
    vin[1] = 1'b1; a_in[1] = 8'd77; b_in[1] = 8'd3; rin[1] = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      if (i == 1) vin[1] = 1'b0;
    end
    #1 rst_n = 1'b0;
    #1;
    chk("abort_valid", 1, ovld[1], 0);
    chk("abort_quot", 1, oq[1], 0);
    chk("abort_flags", 1, {odz[1], oov[1]}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("abort_ready", 1, ordy[1], 1);
    run_op(1, 8'd100, 8'd9, 8'd11, 8'd1, 1'b0, 1'b0, 9, 0);

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
